key_gate_bank_seq: RTL and testbench
====================================

// Module: key_gate_bank_seq
// PURPOSE
//  Parametrised, clocked successor to our combinational XOR key-gate netlists. It holds a DATA_W-bit
//  unlock key, loaded serially in CHUNK_W-bit beats over a valid/ready port. Once ARMED, the key is
//  XOR-applied bit-for-bit to a registered data path. Sits between a locked core and its outputs.
//  Until a full key has been loaded, an all-zero key is applied, so the core's outputs stay obfuscated.
// PARAMETERS
//  DATA_W   8  width of the protected data path; the key width equals DATA_W
//  CHUNK_W  2  key bits accepted per load beat; DATA_W % CHUNK_W must be 0 (elaboration $error otherwise)
//  CNT_W    4  width of the saturating completed-load counter
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        synchronous active-low reset
//  key_valid   in   1        key beat offered
//  key_data    in   CHUNK_W  key beat payload
//  key_ready   out  1        key beat accepted when key_valid & key_ready
//  key_clear   in   1        discard any key (active or partial) and return to LOAD
//  in_valid    in   1        data beat valid (no backpressure)
//  in_data     in   DATA_W   locked-core output to be keyed
//  out_valid   out  1        in_valid delayed one cycle
//  out_data    out  DATA_W   in_data ^ active_key, registered
//  armed       out  1        1 while the active key is a fully loaded key
//  load_count  out  CNT_W    number of completed key loads, saturating at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=LOAD, shift_reg=0, beat_cnt=0, active_key=0.
//   Outputs after reset: key_ready=1, out_valid=0, out_data=0, armed=0, load_count=0.
//   Reset mid-load or while ARMED discards all key state; load_count also returns to 0.
//  BEATS = DATA_W/CHUNK_W. beat_cnt width = $clog2(BEATS+1).
//  State LOAD (key_ready=1):
//   - Each accepted beat: shift_reg <= {shift_reg[DATA_W-CHUNK_W-1:0], key_data}, so the first beat
//     ends in the MSBs. beat_cnt increments.
//   - On the BEATS-th accepted beat: the next cycle has state=ARMED and
//     active_key={shift_reg[DATA_W-CHUNK_W-1:0], key_data}. In that same update: beat_cnt=0,
//     shift_reg=0, load_count+1 (saturating), armed=1, key_ready=0.
//   - active_key stays 0 throughout LOAD.
//  State ARMED (key_ready=0): key_valid is ignored; no beat is accepted.
//  key_clear (either state): next cycle has state=LOAD, active_key=0, shift_reg=0, beat_cnt=0,
//   armed=0, key_ready=1.
//   - key_clear wins over a simultaneous accepted beat. That beat is dropped, and the load does not
//     complete even if it was the final beat.
//   - key_clear does not change load_count.
//  Data path, independent of state, latency 1:
//   out_valid <= in_valid; out_data <= in_data ^ active_key (the active_key value in the sampling cycle).
//   - out_data holds its last value when in_valid=0.
//   - A beat sampled in the same cycle as key_clear or key completion uses the old active_key.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package key_gate_pkg:
//   - typedef enum logic {KG_LOAD, KG_ARMED} kg_state_t;
//   - function kg_beats(DATA_W, CHUNK_W).
//  Sub-module key_shift_loader: shift_reg, beat_cnt and the completion pulse.
//   Ports: clk, rst_n, clear, beat_en, key_data, done (1-cycle pulse), key_out.
//  The top level holds the FSM, active_key, load_count and the data register.
// TESTING (DATA_W=8, CHUNK_W=2, CNT_W=4 unless stated)
//  1. Reset, then in_valid=1, in_data=8'h0F -> next cycle out_valid=1, out_data=8'h0F, armed=0, key_ready=1.
//  2. Load beats 2'b10, 2'b11, 2'b00, 2'b01 on consecutive cycles with in_data=8'h0F held:
//     -> armed=1 the cycle after beat 4, load_count=1, key_ready=0;
//     -> out_data=8'hBE from the 2nd cycle after beat 4.
//  3. In ARMED, key_valid=1 with key_data=2'b11 for 3 cycles -> no change to the key; out_data stays
//     8'hBE. Then pulse key_clear -> armed=0 next cycle, out_data=8'h0F one cycle later,
//     load_count still 1.
//  4. Load 3 beats, then key_clear together with the 4th beat -> armed stays 0.
//     A fresh 4-beat load of 8'h5A -> armed=1; in_data=8'h00 -> out_data=8'h5A.
//  5. Complete 17 loads (key_clear between each) -> load_count saturates at 4'hF.
//     rst_n=0 mid-load -> load_count=0, armed=0, out_valid=0, out_data=0.
//  6. Parameter sweep DATA_W=16, CHUNK_W=4, key 16'hA5C3, random in_data for 1000 cycles ->
//     scoreboard out_data == in_data_d1 ^ active_key every out_valid cycle.

Source files
------------

// File: rtl/key_gate_pkg.sv
// Shared types and helpers for the clocked XOR key-gate bank.
package key_gate_pkg;

   typedef enum logic {
      KG_LOAD  = 1'b0,
      KG_ARMED = 1'b1
   } kg_state_t;

   // Number of load beats needed to assemble one full key.
   function automatic int kg_beats(input int data_w, input int chunk_w);
      return data_w / chunk_w;
   endfunction

endpackage

// File: rtl/key_gate_bank_seq_if.sv
// Key-load handshake plus keyed data path of the key-gate bank.
interface key_gate_bank_seq_if #(
   parameter int DATA_W  = 8,
   parameter int CHUNK_W = 2
);
   logic               key_valid;
   logic [CHUNK_W-1:0] key_data;
   logic               key_ready;
   logic               key_clear;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;

   modport master (
      output key_valid, key_data, key_clear, in_valid, in_data,
      input  key_ready, out_valid, out_data
   );

   modport slave (
      input  key_valid, key_data, key_clear, in_valid, in_data,
      output key_ready, out_valid, out_data
   );
endinterface

// File: rtl/key_shift_loader.sv
// Serial key assembler: shifts CHUNK_W-bit beats in MSB-first and flags the
// beat that completes a key. done/key_out are combinational so the owner can
// capture the finished key on the same edge that accepts the last beat.
module key_shift_loader
   import key_gate_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CHUNK_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               beat_en,
   input  logic [CHUNK_W-1:0] key_data,
   output logic               done,
   output logic [DATA_W-1:0]  key_out
);
   localparam int BEATS  = kg_beats(DATA_W, CHUNK_W);
   localparam int BCNT_W = $clog2(BEATS + 1);

   logic [DATA_W-1:0]         shift_reg_r;
   logic [BCNT_W-1:0]         beat_cnt_r;
   logic [DATA_W+CHUNK_W-1:0] shift_cat_s;
   logic                      last_beat_s;

   // Shifted key value including the beat currently offered.
   always_comb begin
      shift_cat_s = {shift_reg_r, key_data};
      key_out     = shift_cat_s[DATA_W-1:0];
      last_beat_s = (beat_cnt_r == BCNT_W'(BEATS - 1));
      done        = beat_en & last_beat_s & ~clear;
   end

   // Shift register and beat counter; clear beats a simultaneous beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg_r <= {DATA_W{1'b0}};
         beat_cnt_r  <= {BCNT_W{1'b0}};
      end else if (clear) begin
         shift_reg_r <= {DATA_W{1'b0}};
         beat_cnt_r  <= {BCNT_W{1'b0}};
      end else if (beat_en) begin
         if (last_beat_s) begin
            shift_reg_r <= {DATA_W{1'b0}};
            beat_cnt_r  <= {BCNT_W{1'b0}};
         end else begin
            shift_reg_r <= key_out;
            beat_cnt_r  <= beat_cnt_r + BCNT_W'(1);
         end
      end else begin
         shift_reg_r <= shift_reg_r;
         beat_cnt_r  <= beat_cnt_r;
      end
   end
endmodule

// File: rtl/key_gate_bank_seq.sv
// Clocked XOR key-gate bank: loads an unlock key serially, then XORs it onto
// a registered data path. An all-zero key is applied until a key is complete.
module key_gate_bank_seq
   import key_gate_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CHUNK_W = 2,
   parameter int CNT_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   key_gate_bank_seq_if.slave   bus,
   output logic                 armed,
   output logic [CNT_W-1:0]     load_count
);
   if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
      $error("key_gate_bank_seq: DATA_W must be a multiple of CHUNK_W");
   end

   kg_state_t          state_r;
   logic [DATA_W-1:0]  active_key_r;
   logic [DATA_W-1:0]  out_data_r;
   logic               out_valid_r;
   logic               armed_r;
   logic               key_ready_r;
   logic [CNT_W-1:0]   load_count_r;
   logic               beat_en_s;
   logic               load_done_s;
   logic [DATA_W-1:0]  loaded_key_s;

   // A beat is taken only while loading; key_ready_r mirrors the LOAD state.
   always_comb begin
      beat_en_s = bus.key_valid & key_ready_r & (state_r == KG_LOAD);
   end

   key_shift_loader #(
      .DATA_W  (DATA_W),
      .CHUNK_W (CHUNK_W)
   ) u_loader (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.key_clear),
      .beat_en  (beat_en_s),
      .key_data (bus.key_data),
      .done     (load_done_s),
      .key_out  (loaded_key_s)
   );

   // FSM, active key, load counter and the keyed output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= KG_LOAD;
         active_key_r <= {DATA_W{1'b0}};
         out_data_r   <= {DATA_W{1'b0}};
         out_valid_r  <= 1'b0;
         armed_r      <= 1'b0;
         key_ready_r  <= 1'b1;
         load_count_r <= {CNT_W{1'b0}};
      end else begin
         out_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            out_data_r <= bus.in_data ^ active_key_r;
         end else begin
            out_data_r <= out_data_r;
         end
         if (bus.key_clear) begin
            state_r      <= KG_LOAD;
            active_key_r <= {DATA_W{1'b0}};
            armed_r      <= 1'b0;
            key_ready_r  <= 1'b1;
         end else begin
            case (state_r)
               KG_LOAD: begin
                  if (load_done_s) begin
                     state_r      <= KG_ARMED;
                     active_key_r <= loaded_key_s;
                     armed_r      <= 1'b1;
                     key_ready_r  <= 1'b0;
                     if (load_count_r != {CNT_W{1'b1}}) begin
                        load_count_r <= load_count_r + CNT_W'(1);
                     end else begin
                        load_count_r <= load_count_r;
                     end
                  end else begin
                     state_r <= KG_LOAD;
                  end
               end
               KG_ARMED: begin
                  state_r <= KG_ARMED;
               end
               default: begin
                  state_r      <= KG_LOAD;
                  active_key_r <= {DATA_W{1'b0}};
                  armed_r      <= 1'b0;
                  key_ready_r  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.key_ready = key_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign armed         = armed_r;
   assign load_count    = load_count_r;
endmodule

// File: tb/tb_key_gate_bank_seq.sv
// Directed, table-driven bench for key_gate_bank_seq (8/2/4 instance) plus a
// 16/4 instance exercised with a random data stream against a scoreboard.
module tb_key_gate_bank_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   key_gate_bank_seq_if #(.DATA_W(8),  .CHUNK_W(2)) bus8 ();
   key_gate_bank_seq_if #(.DATA_W(16), .CHUNK_W(4)) bus16 ();
   logic       armed8,  armed16;
   logic [3:0] cnt8,    cnt16;

   key_gate_bank_seq #(.DATA_W(8), .CHUNK_W(2), .CNT_W(4)) u_dut8 (
      .clk (clk), .rst_n (rst_n), .bus (bus8), .armed (armed8), .load_count (cnt8)
   );
   key_gate_bank_seq #(.DATA_W(16), .CHUNK_W(4), .CNT_W(4)) u_dut16 (
      .clk (clk), .rst_n (rst_n), .bus (bus16), .armed (armed16), .load_count (cnt16)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst_n;
      logic       kv;
      logic [1:0] kd;
      logic       kc;
      logic       iv;
      logic [7:0] id;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_arm;
      logic       e_rdy;
      logic [3:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic kv, input logic [1:0] kd,
                               input logic kc, input logic iv, input logic [7:0] id,
                               input logic eov, input logic [7:0] eod, input logic earm,
                               input logic erdy, input logic [3:0] ecnt);
      vec_t v;
      v.rst_n = r;  v.kv = kv; v.kd = kd; v.kc = kc; v.iv = iv; v.id = id;
      v.e_ov = eov; v.e_od = eod; v.e_arm = earm; v.e_rdy = erdy; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string tag, input logic eov, input logic [7:0] eod,
                         input logic earm, input logic erdy, input logic [3:0] ecnt);
      check({tag, ".out_valid"}, 32'(bus8.out_valid), 32'(eov));
      check({tag, ".out_data"},  32'(bus8.out_data),  32'(eod));
      check({tag, ".armed"},     32'(armed8),         32'(earm));
      check({tag, ".key_ready"}, 32'(bus8.key_ready), 32'(erdy));
      check({tag, ".load_count"},32'(cnt8),           32'(ecnt));
   endtask

   task automatic load8(input logic [7:0] key);
      for (int b = 0; b < 4; b++) begin
         bus8.key_valid = 1'b1;
         bus8.key_data  = key[7-2*b -: 2];
         tick();
      end
      bus8.key_valid = 1'b0;
   endtask

   vec_t vecs[22];

   initial begin
      // reset / pass-through / first load / ARMED ignores beats / clear
      vecs[0]  = mk(1'b0,1'b0,2'b00,1'b0,1'b0,8'h00, 1'b0,8'h00,1'b0,1'b1,4'd0);
      vecs[1]  = mk(1'b1,1'b0,2'b00,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd0);
      vecs[2]  = mk(1'b1,1'b1,2'b10,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd0);
      vecs[3]  = mk(1'b1,1'b1,2'b11,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd0);
      vecs[4]  = mk(1'b1,1'b1,2'b00,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd0);
      vecs[5]  = mk(1'b1,1'b1,2'b01,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b1,1'b0,4'd1);
      vecs[6]  = mk(1'b1,1'b0,2'b00,1'b0,1'b1,8'h0F, 1'b1,8'hBE,1'b1,1'b0,4'd1);
      vecs[7]  = mk(1'b1,1'b1,2'b11,1'b0,1'b1,8'h0F, 1'b1,8'hBE,1'b1,1'b0,4'd1);
      vecs[8]  = mk(1'b1,1'b1,2'b11,1'b0,1'b1,8'h0F, 1'b1,8'hBE,1'b1,1'b0,4'd1);
      vecs[9]  = mk(1'b1,1'b1,2'b11,1'b0,1'b1,8'h0F, 1'b1,8'hBE,1'b1,1'b0,4'd1);
      vecs[10] = mk(1'b1,1'b0,2'b00,1'b1,1'b1,8'h0F, 1'b1,8'hBE,1'b0,1'b1,4'd1);
      vecs[11] = mk(1'b1,1'b0,2'b00,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      // three beats, clear with the fourth, then a fresh 8'h5A load
      vecs[12] = mk(1'b1,1'b1,2'b01,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[13] = mk(1'b1,1'b1,2'b01,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[14] = mk(1'b1,1'b1,2'b10,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[15] = mk(1'b1,1'b1,2'b10,1'b1,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[16] = mk(1'b1,1'b1,2'b01,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[17] = mk(1'b1,1'b1,2'b01,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[18] = mk(1'b1,1'b1,2'b10,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b0,1'b1,4'd1);
      vecs[19] = mk(1'b1,1'b1,2'b10,1'b0,1'b1,8'h0F, 1'b1,8'h0F,1'b1,1'b0,4'd2);
      vecs[20] = mk(1'b1,1'b0,2'b00,1'b0,1'b1,8'h00, 1'b1,8'h5A,1'b1,1'b0,4'd2);
      vecs[21] = mk(1'b1,1'b0,2'b00,1'b0,1'b0,8'hFF, 1'b0,8'h5A,1'b1,1'b0,4'd2);

      bus16.key_valid = 1'b0; bus16.key_data = 4'h0; bus16.key_clear = 1'b0;
      bus16.in_valid  = 1'b0; bus16.in_data  = 16'h0000;
      rst_n = 1'b0;
      bus8.key_valid = 1'b0; bus8.key_data = 2'b00; bus8.key_clear = 1'b0;
      bus8.in_valid  = 1'b0; bus8.in_data  = 8'h00;
      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         rst_n          = vecs[i].rst_n;
         bus8.key_valid = vecs[i].kv;
         bus8.key_data  = vecs[i].kd;
         bus8.key_clear = vecs[i].kc;
         bus8.in_valid  = vecs[i].iv;
         bus8.in_data   = vecs[i].id;
         tick();
         check8($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                vecs[i].e_arm, vecs[i].e_rdy, vecs[i].e_cnt);
      end

      // count saturation: loads 3..17 with a clear before each
      bus8.in_valid = 1'b0;
      for (int n = 3; n <= 17; n++) begin
         bus8.key_clear = 1'b1;
         tick();
         bus8.key_clear = 1'b0;
         load8(8'h5A);
         check("sat.armed", 32'(armed8), 32'd1);
         check($sformatf("sat.load_count%0d", n), 32'(cnt8), (n > 15) ? 32'd15 : 32'(n));
      end

      // reset in the middle of a load
      bus8.key_clear = 1'b1;
      tick();
      bus8.key_clear = 1'b0;
      bus8.key_valid = 1'b1; bus8.key_data = 2'b11; tick(); tick();
      bus8.in_valid  = 1'b1; bus8.in_data = 8'h33;
      rst_n = 1'b0;
      tick();
      check8("midrst", 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
      rst_n = 1'b1; bus8.key_valid = 1'b0; bus8.in_valid = 1'b0;
      tick();
      check8("postrst", 1'b0, 8'h00, 1'b0, 1'b1, 4'd0);

      // 16-bit instance: load 16'hA5C3 in 4-bit beats, then random stream
      begin
         logic [15:0] key16;
         logic [15:0] exp_od16;
         logic        iv;
         logic [15:0] id;
         key16 = 16'hA5C3;
         for (int b = 0; b < 4; b++) begin
            bus16.key_valid = 1'b1;
            bus16.key_data  = key16[15-4*b -: 4];
            tick();
         end
         bus16.key_valid = 1'b0;
         check("w16.armed",      32'(armed16),         32'd1);
         check("w16.key_ready",  32'(bus16.key_ready), 32'd0);
         check("w16.load_count", 32'(cnt16),           32'd1);
         exp_od16 = 16'h0000;
         for (int c = 0; c < 1000; c++) begin
            iv = 1'($urandom_range(0, 1));
            id = 16'($urandom);
            bus16.in_valid = iv;
            bus16.in_data  = id;
            tick();
            if (iv) exp_od16 = id ^ key16;
            check("w16.out_valid", 32'(bus16.out_valid), 32'(iv));
            check("w16.out_data",  32'(bus16.out_data),  32'(exp_od16));
         end
         bus16.in_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
